// File: rtl/exu_gpr_wb_sched_pkg.sv
// Shared EXU datapath definitions for the GPR writeback scheduler:
// default widths, load-credit depth and the GPR write-port bundle.
package exu_gpr_wb_sched_pkg;

    localparam int DP_XLEN   = 32;
    localparam int DP_GPR_AW = 5;
    localparam int DP_MAX_LD = 2;

    // One GPR write-port transaction as seen by the register file.
    typedef struct packed {
        logic                 wen;
        logic [DP_GPR_AW-1:0] waddr;
        logic [DP_XLEN-1:0]   wdata;
    } gpr_wr_t;

endpackage

// File: rtl/exu_gpr_wb_sched_scoreboard.sv
// Per-register pending bits for loads in flight. One set port (load
// issue), one clear port (load writeback), and combinational lookups
// for both sources plus the destination (WAW).
module exu_gpr_scoreboard #(
    parameter int GPR_AW = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     set_en,
    input  logic [GPR_AW-1:0]        set_addr,
    input  logic                     clr_en,
    input  logic [GPR_AW-1:0]        clr_addr,
    input  logic [GPR_AW-1:0]        rs1,
    input  logic [GPR_AW-1:0]        rs2,
    input  logic [GPR_AW-1:0]        rd,
    output logic                     rs1_pend,
    output logic                     rs2_pend,
    output logic                     rd_pend,
    output logic [(1<<GPR_AW)-1:0]   pend
);

    logic [(1<<GPR_AW)-1:0] pend_q;
    logic [(1<<GPR_AW)-1:0] pend_nxt;

    // Next pending vector: clear on writeback, set on load issue; x0 never pends.
    always_comb begin
        pend_nxt = pend_q;
        if (clr_en) begin
            pend_nxt[clr_addr] = 1'b0;
        end
        if (set_en && set_addr != '0) begin
            pend_nxt[set_addr] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    // Pending vector register, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_nxt;
        end
    end

    assign rs1_pend = pend_q[rs1];
    assign rs2_pend = pend_q[rs2];
    assign rd_pend  = (rd != '0) & pend_q[rd];
    assign pend     = pend_q;

endmodule

// File: rtl/exu_gpr_wb_sched.sv
// Arbitrates the single GPR write port between the execute path and
// LSU load writebacks. The LSU always wins; execute requests stall on
// RAW/WAW against loads in flight, on load-credit exhaustion, and when
// they would need the write port in a cycle the LSU already owns it.
module exu_gpr_wb_sched
    import exu_gpr_wb_sched_pkg::*;
#(
    parameter int XLEN   = DP_XLEN,
    parameter int GPR_AW = DP_GPR_AW,
    parameter int MAX_LD = DP_MAX_LD
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ex_req_vld,
    output logic                          ex_req_rdy,
    output logic                          ex_req_hsk,
    input  logic [GPR_AW-1:0]             ex_rs1,
    input  logic                          ex_rs1_used,
    input  logic [GPR_AW-1:0]             ex_rs2,
    input  logic                          ex_rs2_used,
    input  logic [GPR_AW-1:0]             ex_rd,
    input  logic                          ex_wen,
    input  logic                          ex_is_load,
    input  logic [XLEN-1:0]               ex_wdata,
    input  logic                          lsu_wb_vld,
    output logic                          lsu_wb_rdy,
    input  logic [GPR_AW-1:0]             lsu_wb_addr,
    input  logic [XLEN-1:0]               lsu_wb_data,
    output logic                          gpr_wen,
    output logic [GPR_AW-1:0]             gpr_waddr,
    output logic [XLEN-1:0]               gpr_wdata,
    output logic [$clog2(MAX_LD+1)-1:0]   ld_outstanding
);

    localparam int CNT_W = $clog2(MAX_LD + 1);

    logic                    lsu_hsk;
    logic                    ld_hsk;
    logic                    rs1_pend;
    logic                    rs2_pend;
    logic                    rd_pend;
    logic                    ld_full;
    logic [CNT_W-1:0]        ld_cnt;
    logic [(1<<GPR_AW)-1:0]  pend;
    gpr_wr_t                 wp;

    // Writebacks are never back-pressured; only reset withholds ready.
    assign lsu_wb_rdy = rst_n;
    assign lsu_hsk    = lsu_wb_vld & lsu_wb_rdy;
    assign ld_full    = (ld_cnt == CNT_W'(MAX_LD));

    // Same-cycle RAW with the writeback still stalls: pend clears at the edge.
    assign ex_req_rdy = rst_n
                      & ~(ex_rs1_used & rs1_pend)
                      & ~(ex_rs2_used & rs2_pend)
                      & ~((ex_wen | ex_is_load) & rd_pend)
                      & ~(ex_is_load & ld_full)
                      & ~(ex_wen & lsu_wb_vld);
    assign ex_req_hsk = ex_req_vld & ex_req_rdy;
    assign ld_hsk     = ex_req_hsk & ex_is_load;

    exu_gpr_scoreboard #(
        .GPR_AW (GPR_AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (ld_hsk),
        .set_addr (ex_rd),
        .clr_en   (lsu_hsk),
        .clr_addr (lsu_wb_addr),
        .rs1      (ex_rs1),
        .rs2      (ex_rs2),
        .rd       (ex_rd),
        .rs1_pend (rs1_pend),
        .rs2_pend (rs2_pend),
        .rd_pend  (rd_pend),
        .pend     (pend)
    );

    // Write-port mux: LSU first, then an accepted execute write; x0 is never written.
    always_comb begin
        wp = '0;
        if (lsu_hsk && lsu_wb_addr != '0) begin
            wp.wen   = 1'b1;
            wp.waddr = lsu_wb_addr;
            wp.wdata = lsu_wb_data;
        end else if (ex_req_hsk && ex_wen && ex_rd != '0) begin
            wp.wen   = 1'b1;
            wp.waddr = ex_rd;
            wp.wdata = ex_wdata;
        end
    end

    assign gpr_wen   = wp.wen;
    assign gpr_waddr = wp.waddr;
    assign gpr_wdata = wp.wdata;

    // Load credit counter: issue and return in the same cycle cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt <= '0;
        end else if (ld_hsk && !lsu_hsk) begin
            ld_cnt <= ld_cnt + 1'b1;
        end else if (!ld_hsk && lsu_hsk) begin
            ld_cnt <= ld_cnt - 1'b1;
        end
    end

    assign ld_outstanding = ld_cnt;

    a_wen_and_load : assert property (@(posedge clk) disable iff (!rst_n)
        !(ex_req_vld && ex_wen && ex_is_load));

    a_wb_without_load : assert property (@(posedge clk) disable iff (!rst_n)
        !(lsu_wb_vld && ld_cnt == '0));

    a_wb_not_pending : assert property (@(posedge clk) disable iff (!rst_n)
        !(lsu_wb_vld && lsu_wb_addr != '0 && !pend[lsu_wb_addr]));

endmodule

// File: tb/tb_exu_gpr_wb_sched.sv
// Scoreboard bench for exu_gpr_wb_sched: a driver issues directed and
// random cycles and queues the expected response computed from a
// list of loads in flight; a monitor on the falling edge pops and compares.
module tb_exu_gpr_wb_sched;

    localparam int XLEN   = 32;
    localparam int GPR_AW = 5;
    localparam int MAX_LD = 2;
    localparam int CW     = $clog2(MAX_LD + 1);

    logic              clk;
    logic              rst_n;
    logic              ex_req_vld;
    logic              ex_req_rdy;
    logic              ex_req_hsk;
    logic [GPR_AW-1:0] ex_rs1;
    logic              ex_rs1_used;
    logic [GPR_AW-1:0] ex_rs2;
    logic              ex_rs2_used;
    logic [GPR_AW-1:0] ex_rd;
    logic              ex_wen;
    logic              ex_is_load;
    logic [XLEN-1:0]   ex_wdata;
    logic              lsu_wb_vld;
    logic              lsu_wb_rdy;
    logic [GPR_AW-1:0] lsu_wb_addr;
    logic [XLEN-1:0]   lsu_wb_data;
    logic              gpr_wen;
    logic [GPR_AW-1:0] gpr_waddr;
    logic [XLEN-1:0]   gpr_wdata;
    logic [CW-1:0]     ld_outstanding;

    exu_gpr_wb_sched #(
        .XLEN   (XLEN),
        .GPR_AW (GPR_AW),
        .MAX_LD (MAX_LD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_req_vld     (ex_req_vld),
        .ex_req_rdy     (ex_req_rdy),
        .ex_req_hsk     (ex_req_hsk),
        .ex_rs1         (ex_rs1),
        .ex_rs1_used    (ex_rs1_used),
        .ex_rs2         (ex_rs2),
        .ex_rs2_used    (ex_rs2_used),
        .ex_rd          (ex_rd),
        .ex_wen         (ex_wen),
        .ex_is_load     (ex_is_load),
        .ex_wdata       (ex_wdata),
        .lsu_wb_vld     (lsu_wb_vld),
        .lsu_wb_rdy     (lsu_wb_rdy),
        .lsu_wb_addr    (lsu_wb_addr),
        .lsu_wb_data    (lsu_wb_data),
        .gpr_wen        (gpr_wen),
        .gpr_waddr      (gpr_waddr),
        .gpr_wdata      (gpr_wdata),
        .ld_outstanding (ld_outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              rdy;
        logic              hsk;
        logic              gwen;
        logic [GPR_AW-1:0] waddr;
        logic [XLEN-1:0]   wdata;
        int                cnt;
    } exp_t;

    exp_t            expq[$];
    logic [GPR_AW-1:0] infl[$];   // destination of every load in flight
    int              n_cmp = 0;
    int              n_bad = 0;

    function automatic bit is_pend(input logic [GPR_AW-1:0] r);
        if (r == '0) return 1'b0;
        foreach (infl[i]) if (infl[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One cycle of stimulus; kind 0 = no GPR write, 1 = execute write, 2 = load.
    task automatic step(input bit vld, input logic [GPR_AW-1:0] rs1, input bit r1u,
                        input logic [GPR_AW-1:0] rs2, input bit r2u,
                        input logic [GPR_AW-1:0] rd, input int kind, input logic [XLEN-1:0] wd,
                        input bit lv, input logic [GPR_AW-1:0] la, input logic [XLEN-1:0] lw);
        exp_t e;
        bit   wen;
        bit   ld;
        @(posedge clk);
        #1;
        wen = (kind == 1);
        ld  = (kind == 2);
        ex_req_vld  = vld;
        ex_rs1      = rs1;
        ex_rs1_used = r1u;
        ex_rs2      = rs2;
        ex_rs2_used = r2u;
        ex_rd       = rd;
        ex_wen      = wen;
        ex_is_load  = ld;
        ex_wdata    = wd;
        lsu_wb_vld  = lv;
        lsu_wb_addr = la;
        lsu_wb_data = lw;
        e.cnt = infl.size();
        e.rdy = !(r1u && is_pend(rs1)) && !(r2u && is_pend(rs2))
             && !((wen || ld) && is_pend(rd))
             && !(ld && infl.size() == MAX_LD)
             && !(wen && lv);
        e.hsk = vld && e.rdy;
        if (lv && la != '0) begin
            e.gwen = 1'b1; e.waddr = la; e.wdata = lw;
        end else if (e.hsk && wen && rd != '0) begin
            e.gwen = 1'b1; e.waddr = rd; e.wdata = wd;
        end else begin
            e.gwen = 1'b0; e.waddr = '0; e.wdata = '0;
        end
        expq.push_back(e);
        if (lv) begin
            for (int i = 0; i < infl.size(); i++) begin
                if (infl[i] == la) begin
                    infl.delete(i);
                    break;
                end
            end
        end
        if (e.hsk && ld) infl.push_back(rd);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wb(input logic [GPR_AW-1:0] a, input logic [XLEN-1:0] d);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, a, d);
    endtask

    // Monitor: compare every queued expectation against the DUT mid-cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("ex_req_rdy", 32'(ex_req_rdy), 32'(e.rdy));
            chk("ex_req_hsk", 32'(ex_req_hsk), 32'(e.hsk));
            chk("gpr_wen", 32'(gpr_wen), 32'(e.gwen));
            if (e.gwen) begin
                chk("gpr_waddr", 32'(gpr_waddr), 32'(e.waddr));
                chk("gpr_wdata", gpr_wdata, e.wdata);
            end
            chk("ld_outstanding", 32'(ld_outstanding), 32'(e.cnt));
            chk("lsu_wb_rdy", 32'(lsu_wb_rdy), 32'd1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ex_req_vld = 1'b1; ex_rs1 = '0; ex_rs1_used = 1'b0; ex_rs2 = '0; ex_rs2_used = 1'b0;
        ex_rd = 5'd3; ex_wen = 1'b1; ex_is_load = 1'b0; ex_wdata = 32'hdead_beef;
        lsu_wb_vld = 1'b1; lsu_wb_addr = 5'd4; lsu_wb_data = 32'h1111_2222;
        #12;
        chk("reset gpr_wen", 32'(gpr_wen), 32'd0);
        chk("reset ex_req_rdy", 32'(ex_req_rdy), 32'd0);
        chk("reset ex_req_hsk", 32'(ex_req_hsk), 32'd0);
        chk("reset lsu_wb_rdy", 32'(lsu_wb_rdy), 32'd0);
        chk("reset ld_outstanding", 32'(ld_outstanding), 32'd0);
        ex_req_vld = 1'b0; ex_wen = 1'b0; lsu_wb_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Load x5, dependent ADDI stalls until the writeback, then issues.
        step(1, 0, 0, 0, 0, 5, 2, 0, 0, 0, 0);
        step(1, 5, 1, 0, 0, 6, 1, 32'h6, 0, 0, 0);
        step(1, 5, 1, 0, 0, 6, 1, 32'h6, 1, 5, 32'h1234);
        step(1, 5, 1, 0, 0, 6, 1, 32'h6, 0, 0, 0);

        // LUI x7 loses the write port to the LSU, then wins next cycle.
        step(1, 0, 0, 0, 0, 5, 2, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 7, 1, 32'h7000, 1, 5, 32'h55);
        step(1, 0, 0, 0, 0, 7, 1, 32'h7000, 0, 0, 0);

        // Credit exhaustion: third load waits even while a credit returns.
        step(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 3, 2, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 3, 2, 0, 1, 1, 32'haaaa);
        step(1, 0, 0, 0, 0, 3, 2, 0, 0, 0, 0);
        wb(2, 32'h2222);
        wb(3, 32'h3333);

        // Load to x0 consumes a credit but never pends or writes.
        step(1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 9, 1, 32'h99, 0, 0, 0);
        wb(0, 32'hffff);

        // WAW on x4: second load waits for the first writeback.
        step(1, 0, 0, 0, 0, 4, 2, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 4, 2, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 4, 2, 0, 1, 4, 32'h4444);
        step(1, 0, 0, 0, 0, 4, 2, 0, 0, 0, 0);
        wb(4, 32'h4545);

        // Random traffic over a small register window to provoke hazards.
        for (int n = 0; n < 600; n++) begin
            bit lv;
            logic [GPR_AW-1:0] la;
            lv = (infl.size() > 0) && ($urandom_range(0, 1) == 1);
            la = lv ? infl[$urandom_range(0, infl.size() - 1)] : GPR_AW'($urandom_range(0, 7));
            step($urandom_range(0, 3) != 0,
                 GPR_AW'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                 GPR_AW'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                 GPR_AW'($urandom_range(0, 7)), $urandom_range(0, 2), $urandom,
                 lv, la, $urandom);
        end
        while (infl.size() > 0) wb(infl[0], $urandom);

        // Two loads pending, then asynchronous reset mid-cycle.
        step(1, 0, 0, 0, 0, 4, 2, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 9, 2, 0, 0, 0, 0);
        idle();
        @(negedge clk);
        #1;
        ex_req_vld = 1'b1; ex_rd = 5'd7; ex_wen = 1'b1; ex_is_load = 1'b0;
        lsu_wb_vld = 1'b1; lsu_wb_addr = 5'd4; lsu_wb_data = 32'h4444;
        #1;
        rst_n = 1'b0;
        #1;
        chk("async reset gpr_wen", 32'(gpr_wen), 32'd0);
        chk("async reset ex_req_hsk", 32'(ex_req_hsk), 32'd0);
        chk("async reset ld_outstanding", 32'(ld_outstanding), 32'd0);
        chk("async reset lsu_wb_rdy", 32'(lsu_wb_rdy), 32'd0);
        ex_req_vld = 1'b0; ex_wen = 1'b0; lsu_wb_vld = 1'b0;
        infl.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // ADDI x6,x4 must issue immediately: nothing pends after reset.
        step(1, 4, 1, 0, 0, 6, 1, 32'h66, 0, 0, 0);
        idle();

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
